// File: rtl/adau1761_cfg_sequencer.sv
// adau1761_cfg_sequencer
//   AXI4-Lite master that walks a configuration table and writes each entry
//   into the adau1761_data register bank, optionally reading it back and
//   comparing. Reports a done pulse, or a sticky error with code and index.
//
// Ports
//   ACLK, ARESETN          clock, synchronous active-low reset
//   start                  pulse, starts a sequence when idle
//   busy / done / error    status (done is a 1-cycle pulse, error is sticky)
//   err_code / err_index   1=BRESP 2=RRESP 3=readback mismatch 4=timeout
//   tbl_index              table row being processed
//   tbl_addr / tbl_data    table row contents, combinational from tbl_index
//   m_axi_*                AXI4-Lite master (AW, W, B, AR, R channels)
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for start
// WR      | AW and W offered; each valid drops after its own handshake
// WRESP   | waiting for B
// RD      | AR offered with the address just written
// RDATA   | waiting for R, read data captured
// CHECK   | captured read data compared against the written data
// NEXT    | index already advanced; back to WR or on to FIN
// FIN     | done pulse
// ERR     | error flag, code and index latched
module adau1761_cfg_sequencer #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int NUM_ENTRIES = 4,
   parameter bit VERIFY      = 1'b1,
   parameter int TIMEOUT     = 256
) (
   input  logic              ACLK,
   input  logic              ARESETN,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [2:0]        err_code,
   output logic [7:0]        err_index,
   output logic [7:0]        tbl_index,
   input  logic [ADDR_W-1:0] tbl_addr,
   input  logic [DATA_W-1:0] tbl_data,
   output logic [ADDR_W-1:0] m_axi_awaddr,
   output logic [2:0]        m_axi_awprot,
   output logic              m_axi_awvalid,
   input  logic              m_axi_awready,
   output logic [DATA_W-1:0] m_axi_wdata,
   output logic [3:0]        m_axi_wstrb,
   output logic              m_axi_wvalid,
   input  logic              m_axi_wready,
   input  logic [1:0]        m_axi_bresp,
   input  logic              m_axi_bvalid,
   output logic              m_axi_bready,
   output logic [ADDR_W-1:0] m_axi_araddr,
   output logic [2:0]        m_axi_arprot,
   output logic              m_axi_arvalid,
   input  logic              m_axi_arready,
   input  logic [DATA_W-1:0] m_axi_rdata,
   input  logic [1:0]        m_axi_rresp,
   input  logic              m_axi_rvalid,
   output logic              m_axi_rready
);

   typedef enum logic [3:0] {
      S_IDLE, S_WR, S_WRESP, S_RD, S_RDATA, S_CHECK, S_NEXT, S_FIN, S_ERR
   } state_t;

   localparam int               TMR_W    = $clog2(TIMEOUT + 1);
   localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT - 1);
   localparam logic [7:0]       LAST_IDX = 8'(NUM_ENTRIES - 1);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [2:0]        w_err_code_nxt;
   logic [TMR_W-1:0]  r_tmr;
   logic              r_aw_done;
   logic              r_w_done;
   logic              r_last;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_data;
   logic [DATA_W-1:0] r_rdata;
   logic              r_error;
   logic [2:0]        r_err_code;
   logic [7:0]        r_err_index;
   logic [7:0]        r_tbl_index;
   logic              w_aw_ok;
   logic              w_w_ok;
   logic              w_tmo;
   logic              w_enter;
   logic              w_load;

   assign w_aw_ok = r_aw_done | (m_axi_awvalid & m_axi_awready);
   assign w_w_ok  = r_w_done  | (m_axi_wvalid  & m_axi_wready);
   // timer counts down from TIMEOUT-1 on state entry; zero marks the last allowed cycle
   assign w_tmo   = (r_tmr == '0);
   assign w_enter = (w_state_nxt != r_state);
   // table row is sampled while tbl_index already points at it (IDLE keeps index 0)
   assign w_load  = ((r_state == S_IDLE) && start) || ((r_state == S_NEXT) && !r_last);

   always_ff @(posedge ACLK) begin
      if (!ARESETN) begin
         r_state     <= S_IDLE;
         r_tmr       <= TMR_LOAD;
         r_aw_done   <= 1'b0;
         r_w_done    <= 1'b0;
         r_last      <= 1'b0;
         r_addr      <= '0;
         r_data      <= '0;
         r_rdata     <= '0;
         r_error     <= 1'b0;
         r_err_code  <= 3'd0;
         r_err_index <= 8'd0;
         r_tbl_index <= 8'd0;
      end else begin
         r_state <= w_state_nxt;

         if (w_enter)
            r_tmr <= TMR_LOAD;
         else if (r_tmr != '0)
            r_tmr <= r_tmr - TMR_W'(1);

         r_aw_done <= (r_state == S_WR) & w_aw_ok;
         r_w_done  <= (r_state == S_WR) & w_w_ok;

         if ((r_state == S_RDATA) && m_axi_rvalid)
            r_rdata <= m_axi_rdata;

         if (w_load) begin
            r_addr <= tbl_addr;
            r_data <= tbl_data;
         end

         if ((r_state == S_IDLE) && start) begin
            r_tbl_index <= 8'd0;
            r_error     <= 1'b0;
            r_err_code  <= 3'd0;
         end

         // advance on the way into NEXT so the following row is already on tbl_addr/tbl_data
         if (w_enter && (w_state_nxt == S_NEXT)) begin
            r_last <= (r_tbl_index == LAST_IDX);
            if (r_tbl_index != LAST_IDX)
               r_tbl_index <= r_tbl_index + 8'd1;
         end

         if (w_enter && (w_state_nxt == S_ERR)) begin
            r_error     <= 1'b1;
            r_err_code  <= w_err_code_nxt;
            r_err_index <= r_tbl_index;
         end

         if ((r_state == S_FIN) || (r_state == S_ERR))
            r_tbl_index <= 8'd0;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_err_code_nxt = 3'd0;
      case (r_state)
         S_IDLE: begin
            if (start)
               w_state_nxt = S_WR;
         end
         S_WR: begin
            if (w_aw_ok && w_w_ok) begin
               w_state_nxt = S_WRESP;
            end else if (w_tmo) begin
               w_state_nxt    = S_ERR;
               w_err_code_nxt = 3'd4;
            end
         end
         S_WRESP: begin
            if (m_axi_bvalid) begin
               if (m_axi_bresp != 2'b00) begin
                  w_state_nxt    = S_ERR;
                  w_err_code_nxt = 3'd1;
               end else begin
                  w_state_nxt = (VERIFY != 1'b0) ? S_RD : S_NEXT;
               end
            end else if (w_tmo) begin
               w_state_nxt    = S_ERR;
               w_err_code_nxt = 3'd4;
            end
         end
         S_RD: begin
            if (m_axi_arready) begin
               w_state_nxt = S_RDATA;
            end else if (w_tmo) begin
               w_state_nxt    = S_ERR;
               w_err_code_nxt = 3'd4;
            end
         end
         S_RDATA: begin
            if (m_axi_rvalid) begin
               if (m_axi_rresp != 2'b00) begin
                  w_state_nxt    = S_ERR;
                  w_err_code_nxt = 3'd2;
               end else begin
                  w_state_nxt = S_CHECK;
               end
            end else if (w_tmo) begin
               w_state_nxt    = S_ERR;
               w_err_code_nxt = 3'd4;
            end
         end
         S_CHECK: begin
            if (r_rdata != r_data) begin
               w_state_nxt    = S_ERR;
               w_err_code_nxt = 3'd3;
            end else begin
               w_state_nxt = S_NEXT;
            end
         end
         S_NEXT:  w_state_nxt = r_last ? S_FIN : S_WR;
         S_FIN:   w_state_nxt = S_IDLE;
         S_ERR:   w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      busy          = 1'b0;
      done          = 1'b0;
      m_axi_awvalid = 1'b0;
      m_axi_wvalid  = 1'b0;
      m_axi_bready  = 1'b0;
      m_axi_arvalid = 1'b0;
      m_axi_rready  = 1'b0;
      case (r_state)
         S_WR: begin
            busy          = 1'b1;
            m_axi_awvalid = !r_aw_done;
            m_axi_wvalid  = !r_w_done;
         end
         S_WRESP: begin
            busy         = 1'b1;
            m_axi_bready = 1'b1;
         end
         S_RD: begin
            busy          = 1'b1;
            m_axi_arvalid = 1'b1;
         end
         S_RDATA: begin
            busy         = 1'b1;
            m_axi_rready = 1'b1;
         end
         S_CHECK: busy = 1'b1;
         S_NEXT:  busy = 1'b1;
         S_FIN:   done = 1'b1;
         default: ;
      endcase
   end

   assign error        = r_error;
   assign err_code     = r_err_code;
   assign err_index    = r_err_index;
   assign tbl_index    = r_tbl_index;
   assign m_axi_awaddr = r_addr;
   assign m_axi_araddr = r_addr;
   assign m_axi_wdata  = r_data;
   assign m_axi_awprot = 3'b000;
   assign m_axi_arprot = 3'b000;
   assign m_axi_wstrb  = 4'hF;

endmodule

// File: tb/tb_adau1761_cfg_sequencer.sv
module tb_adau1761_cfg_sequencer;

   localparam logic [31:0] BASE = 32'h43C0_0000;

   logic        ACLK = 1'b0;
   logic        ARESETN = 1'b0;
   logic        start = 1'b0;
   logic        busy, done, error;
   logic [2:0]  err_code;
   logic [7:0]  err_index, tbl_index;
   logic [31:0] tbl_addr, tbl_data;
   logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr;
   logic [2:0]  m_axi_awprot, m_axi_arprot;
   logic [3:0]  m_axi_wstrb;
   logic        m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready;
   logic        m_axi_awready = 1'b0, m_axi_wready = 1'b0, m_axi_bvalid = 1'b0;
   logic        m_axi_arready = 1'b0, m_axi_rvalid = 1'b0;
   logic [1:0]  m_axi_bresp = 2'b00, m_axi_rresp = 2'b00;
   logic [31:0] m_axi_rdata = '0;

   always #5 ACLK = ~ACLK;

   adau1761_cfg_sequencer dut (
      .ACLK(ACLK), .ARESETN(ARESETN), .start(start),
      .busy(busy), .done(done), .error(error),
      .err_code(err_code), .err_index(err_index), .tbl_index(tbl_index),
      .tbl_addr(tbl_addr), .tbl_data(tbl_data),
      .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
      .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
      .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
      .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
      .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
      .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
      .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
      .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
      .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
   );

   function automatic logic [31:0] tbl_word(input logic [7:0] idx);
      case (idx[1:0])
         2'd0:    return 32'h0101_FFFF;
         2'd1:    return 32'hABCD_0001;
         2'd2:    return 32'hDEAD_0011;
         default: return 32'hBEEF_0011;
      endcase
   endfunction

   assign tbl_addr = BASE + {22'd0, tbl_index, 2'b00};
   assign tbl_data = tbl_word(tbl_index);

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s got=0x%08h want=0x%08h", tag, obs, exp);
      end
   endtask

   // scoreboard: {addr,data} of writes and addr of reads the sequencer is expected to issue
   logic [63:0] exp_wr_q[$];
   logic [31:0] exp_rd_q[$];
   logic [31:0] mem [4];

   // slave behaviour knobs
   int aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0;
   int bad_b_idx = -1, bad_r_idx = -1;
   int n_aw = 0, n_w = 0, n_ar = 0;

   // AXI4-Lite slave: samples and drives on the falling edge
   initial begin : slave
      bit          aw_hs, w_hs, b_hs, ar_hs, r_hs;
      bit          have_aw, have_w, b_pend, r_pend;
      int          aw_seen, w_seen, ar_seen, b_cnt;
      logic [31:0] aw_lat, w_lat, ar_lat, wr_addr, wr_data, exp_a;
      logic [3:0]  strb_lat;
      logic [63:0] exp_w;
      {aw_hs, w_hs, b_hs, ar_hs, r_hs, have_aw, have_w, b_pend, r_pend} = '0;
      aw_seen = 0; w_seen = 0; ar_seen = 0; b_cnt = 0;
      aw_lat = '0; w_lat = '0; ar_lat = '0; wr_addr = '0; wr_data = '0; strb_lat = '0;
      forever begin
         @(negedge ACLK);
         if (!ARESETN) begin
            {aw_hs, w_hs, b_hs, ar_hs, r_hs, have_aw, have_w, b_pend, r_pend} = '0;
            aw_seen = 0; w_seen = 0; ar_seen = 0; b_cnt = 0;
            m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0;
            m_axi_arready = 1'b0; m_axi_rvalid = 1'b0;
            continue;
         end
         if (aw_hs) begin have_aw = 1'b1; wr_addr = aw_lat; n_aw++; end
         if (w_hs) begin
            have_w = 1'b1; wr_data = w_lat; n_w++;
            check_eq("wstrb", 32'(strb_lat), 32'hF);
         end
         if (b_hs) b_pend = 1'b0;
         if (r_hs) r_pend = 1'b0;
         if (ar_hs) begin
            n_ar++;
            if (exp_rd_q.size() == 0) check_eq("rd_extra", ar_lat, 32'hFFFF_FFFF);
            else begin
               exp_a = exp_rd_q.pop_front();
               check_eq("rd_addr", ar_lat, exp_a);
            end
            r_pend = 1'b1;
            m_axi_rdata = (int'(ar_lat[3:2]) == bad_r_idx) ? 32'hABCD_0000 : mem[ar_lat[3:2]];
         end
         if (have_aw && have_w && !b_pend) begin
            mem[wr_addr[3:2]] = wr_data;
            if (exp_wr_q.size() == 0) check_eq("wr_extra", wr_addr, 32'hFFFF_FFFF);
            else begin
               exp_w = exp_wr_q.pop_front();
               check_eq("wr_addr", wr_addr, exp_w[63:32]);
               check_eq("wr_data", wr_data, exp_w[31:0]);
            end
            m_axi_bresp = (int'(wr_addr[3:2]) == bad_b_idx) ? 2'b10 : 2'b00;
            have_aw = 1'b0; have_w = 1'b0; b_pend = 1'b1; b_cnt = 0;
         end
         m_axi_bvalid = b_pend && (b_cnt >= b_wait);
         if (b_pend) b_cnt++;
         m_axi_rvalid = r_pend;
         if (m_axi_awvalid && !have_aw) begin m_axi_awready = (aw_seen >= aw_wait); aw_seen++; end
         else begin m_axi_awready = 1'b0; aw_seen = 0; end
         if (m_axi_wvalid && !have_w) begin m_axi_wready = (w_seen >= w_wait); w_seen++; end
         else begin m_axi_wready = 1'b0; w_seen = 0; end
         if (m_axi_arvalid && !r_pend) begin m_axi_arready = (ar_seen >= ar_wait); ar_seen++; end
         else begin m_axi_arready = 1'b0; ar_seen = 0; end
         aw_lat = m_axi_awaddr; w_lat = m_axi_wdata; strb_lat = m_axi_wstrb; ar_lat = m_axi_araddr;
         aw_hs = m_axi_awvalid && m_axi_awready;
         w_hs  = m_axi_wvalid && m_axi_wready;
         ar_hs = m_axi_arvalid && m_axi_arready;
         b_hs  = m_axi_bvalid && m_axi_bready;
         r_hs  = m_axi_rvalid && m_axi_rready;
      end
   end

   task automatic push_entry(input int i, input bit rd);
      exp_wr_q.push_back({BASE + 32'(i * 4), tbl_word(8'(i))});
      if (rd) exp_rd_q.push_back(BASE + 32'(i * 4));
   endtask

   task automatic clear_bench();
      exp_wr_q.delete(); exp_rd_q.delete();
      n_aw = 0; n_w = 0; n_ar = 0;
      aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0;
      bad_b_idx = -1; bad_r_idx = -1;
   endtask

   task automatic bench_reset();
      @(negedge ACLK);
      ARESETN = 1'b0; start = 1'b0;
      repeat (2) @(negedge ACLK);
      ARESETN = 1'b1;
      clear_bench();
   endtask

   // pulses start and counts rising edges until done or error is seen
   task automatic run_seq(output int cyc, output bit saw_done);
      cyc = 0; saw_done = 1'b0;
      @(negedge ACLK);
      start = 1'b1;
      for (int k = 0; k < 2000; k++) begin
         @(posedge ACLK);
         cyc++;
         @(negedge ACLK);
         start = 1'b0;
         if (done) begin saw_done = 1'b1; break; end
         if (error) break;
      end
      if (!saw_done && !error) check_eq("seq_bound", 32'(cyc), 32'd0);
   endtask

   task automatic check_reset_values(input string t);
      check_eq({t, "_busy"},     32'(busy), 32'd0);
      check_eq({t, "_done"},     32'(done), 32'd0);
      check_eq({t, "_error"},    32'(error), 32'd0);
      check_eq({t, "_err_code"}, 32'(err_code), 32'd0);
      check_eq({t, "_err_idx"},  32'(err_index), 32'd0);
      check_eq({t, "_tbl_idx"},  32'(tbl_index), 32'd0);
      check_eq({t, "_valids"},
               32'({m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}), 32'd0);
   endtask

   initial begin : main
      int cyc;
      bit saw;
      bit hit;

      ARESETN = 1'b0;
      repeat (3) @(negedge ACLK);
      check_reset_values("rst");
      check_eq("rst_prot", 32'({m_axi_awprot, m_axi_arprot}), 32'd0);
      check_eq("rst_wstrb", 32'(m_axi_wstrb), 32'hF);
      ARESETN = 1'b1;
      clear_bench();

      // T1: zero-wait slave, full table with readback
      for (int i = 0; i < 4; i++) push_entry(i, 1'b1);
      run_seq(cyc, saw);
      check_eq("t1_done", 32'(saw), 32'd1);
      check_eq("t1_latency", 32'(cyc), 32'd25);
      check_eq("t1_error", 32'(error), 32'd0);
      check_eq("t1_aw_beats", 32'(n_aw), 32'd4);
      check_eq("t1_ar_beats", 32'(n_ar), 32'd4);
      check_eq("t1_wr_left", 32'(exp_wr_q.size()), 32'd0);
      check_eq("t1_rd_left", 32'(exp_rd_q.size()), 32'd0);
      for (int i = 0; i < 4; i++) check_eq("t1_mem", mem[i], tbl_word(8'(i)));
      @(negedge ACLK);
      check_eq("t1_done_pulse", 32'(done), 32'd0);
      check_eq("t1_busy", 32'(busy), 32'd0);

      // T2: awready 3 cycles after wready, bvalid 2 cycles later
      clear_bench();
      aw_wait = 3; b_wait = 2;
      for (int i = 0; i < 4; i++) push_entry(i, 1'b1);
      run_seq(cyc, saw);
      check_eq("t2_done", 32'(saw), 32'd1);
      check_eq("t2_aw_beats", 32'(n_aw), 32'd4);
      check_eq("t2_w_beats", 32'(n_w), 32'd4);
      check_eq("t2_wr_left", 32'(exp_wr_q.size()), 32'd0);

      // T3: SLVERR on write of entry 2
      bench_reset();
      bad_b_idx = 2;
      push_entry(0, 1'b1); push_entry(1, 1'b1); push_entry(2, 1'b0);
      run_seq(cyc, saw);
      check_eq("t3_done", 32'(saw), 32'd0);
      check_eq("t3_error", 32'(error), 32'd1);
      check_eq("t3_err_code", 32'(err_code), 32'd1);
      check_eq("t3_err_idx", 32'(err_index), 32'd2);
      check_eq("t3_busy", 32'(busy), 32'd0);
      repeat (4) @(negedge ACLK);
      check_eq("t3_ar_beats", 32'(n_ar), 32'd2);
      check_eq("t3_wr_left", 32'(exp_wr_q.size()), 32'd0);

      // T4: corrupted readback of entry 1
      bench_reset();
      bad_r_idx = 1;
      push_entry(0, 1'b1); push_entry(1, 1'b1);
      run_seq(cyc, saw);
      check_eq("t4_error", 32'(error), 32'd1);
      check_eq("t4_err_code", 32'(err_code), 32'd3);
      check_eq("t4_err_idx", 32'(err_index), 32'd1);
      repeat (4) @(negedge ACLK);
      check_eq("t4_aw_beats", 32'(n_aw), 32'd2);

      // T5: arready never comes, then a clean rerun
      bench_reset();
      ar_wait = 100000;
      push_entry(0, 1'b0);
      run_seq(cyc, saw);
      check_eq("t5_error", 32'(error), 32'd1);
      check_eq("t5_err_code", 32'(err_code), 32'd4);
      check_eq("t5_err_idx", 32'(err_index), 32'd0);
      check_eq("t5_tmo_cycles", 32'(cyc), 32'd259);
      check_eq("t5_arvalid", 32'(m_axi_arvalid), 32'd0);
      check_eq("t5_ar_beats", 32'(n_ar), 32'd0);
      clear_bench();
      for (int i = 0; i < 4; i++) push_entry(i, 1'b1);
      run_seq(cyc, saw);
      check_eq("t5_rerun_done", 32'(saw), 32'd1);
      check_eq("t5_rerun_error", 32'(error), 32'd0);
      check_eq("t5_rerun_code", 32'(err_code), 32'd0);

      // T6: reset while waiting on B for entry 3, then restart from index 0
      clear_bench();
      b_wait = 3;
      for (int i = 0; i < 4; i++) push_entry(i, 1'b1);
      hit = 1'b0;
      @(negedge ACLK);
      start = 1'b1;
      for (int k = 0; k < 500; k++) begin
         @(negedge ACLK);
         start = 1'b0;
         if (m_axi_bready && (tbl_index == 8'd3)) begin hit = 1'b1; break; end
      end
      check_eq("t6_reach_wresp3", 32'(hit), 32'd1);
      ARESETN = 1'b0;
      @(negedge ACLK);
      check_reset_values("t6");
      @(negedge ACLK);
      ARESETN = 1'b1;
      clear_bench();
      for (int i = 0; i < 4; i++) push_entry(i, 1'b1);
      run_seq(cyc, saw);
      check_eq("t6_done", 32'(saw), 32'd1);
      check_eq("t6_latency", 32'(cyc), 32'd25);
      check_eq("t6_aw_beats", 32'(n_aw), 32'd4);
      check_eq("t6_wr_left", 32'(exp_wr_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
